// File: rtl/mipi_dphy_clk_rst_seq.sv
// D-PHY PLL reset/power-down sequencer.
// Releases out_reset only after the PLL lock has stayed stable.
module mipi_dphy_clk_rst_seq #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int CNT_BITS      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pwrdwn_req,
  input  logic       clear_status,
  input  logic       locked,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       out_reset,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] relock_count,
  output logic [7:0] timeout_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLL_RST   = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_RUN       = 3'd4,
    S_PWRDN     = 3'd5
  } state_t;

  localparam logic [CNT_BITS-1:0] RST_LAST =
    CNT_BITS'(RST_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] TMO_LAST =
    CNT_BITS'(LOCK_TIMEOUT - 1);
  // The sample that enters STABLE already counts as one high cycle.
  localparam logic [CNT_BITS-1:0] STB_LAST =
    CNT_BITS'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);

  state_t              cur;
  state_t              nxt;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_nxt;
  logic                tmo_inc;
  logic                rel_inc;
  logic                sync1;
  logic                locked_sync;

  assign state = cur;

  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt + CNT_BITS'(1);
    tmo_inc = 1'b0;
    rel_inc = 1'b0;
    if (pwrdwn_req) begin
      nxt     = S_PWRDN;
      cnt_nxt = '0;
    end else if (!enable) begin
      nxt     = S_IDLE;
      cnt_nxt = '0;
    end else begin
      unique case (cur)
        S_IDLE: begin
          nxt     = S_PLL_RST;
          cnt_nxt = '0;
        end
        S_PLL_RST: begin
          if (cnt == RST_LAST) begin
            nxt     = S_WAIT_LOCK;
            cnt_nxt = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_sync) begin
            nxt     = S_STABLE;
            cnt_nxt = '0;
          end else if (cnt == TMO_LAST) begin
            nxt     = S_PLL_RST;
            cnt_nxt = '0;
            tmo_inc = 1'b1;
          end
        end
        S_STABLE: begin
          if (!locked_sync) begin
            nxt     = S_WAIT_LOCK;
            cnt_nxt = '0;
          end else if (cnt == STB_LAST) begin
            nxt     = S_RUN;
            cnt_nxt = '0;
          end
        end
        S_RUN: begin
          cnt_nxt = '0;
          if (!locked_sync) begin
            nxt     = S_PLL_RST;
            rel_inc = 1'b1;
          end
        end
        S_PWRDN: begin
          nxt     = S_IDLE;
          cnt_nxt = '0;
        end
        default: begin
          nxt     = S_IDLE;
          cnt_nxt = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they move with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur           <= S_IDLE;
      cnt           <= '0;
      sync1         <= 1'b0;
      locked_sync   <= 1'b0;
      pll_rst       <= 1'b1;
      pll_pwrdwn    <= 1'b0;
      out_reset     <= 1'b1;
      ready         <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      cur         <= nxt;
      cnt         <= cnt_nxt;
      sync1       <= locked;
      locked_sync <= sync1;
      pll_rst     <= (nxt == S_IDLE) || (nxt == S_PLL_RST) ||
                     (nxt == S_PWRDN);
      pll_pwrdwn  <= (nxt == S_PWRDN);
      out_reset   <= (nxt != S_RUN);
      ready       <= (nxt == S_RUN);
      if (clear_status) begin
        relock_count  <= '0;
        timeout_count <= '0;
      end else begin
        if (rel_inc && relock_count != 8'hff)
          relock_count <= relock_count + 8'd1;
        if (tmo_inc && timeout_count != 8'hff)
          timeout_count <= timeout_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mipi_dphy_clk_rst_seq.sv
// Directed bench for the D-PHY PLL sequencer.
// Inputs change and outputs are sampled on the falling edge.
module tb_mipi_dphy_clk_rst_seq;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pwrdwn_req;
  logic       clear_status;
  logic       locked;
  logic       pll_rst;
  logic       pll_pwrdwn;
  logic       out_reset;
  logic       ready;
  logic [2:0] state;
  logic [7:0] relock_count;
  logic [7:0] timeout_count;

  int checks = 0;
  int errors = 0;

  mipi_dphy_clk_rst_seq #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .STABLE_CYCLES(8),
    .CNT_BITS     (20)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pwrdwn_req   (pwrdwn_req),
    .clear_status (clear_status),
    .locked       (locked),
    .pll_rst      (pll_rst),
    .pll_pwrdwn   (pll_pwrdwn),
    .out_reset    (out_reset),
    .ready        (ready),
    .state        (state),
    .relock_count (relock_count),
    .timeout_count(timeout_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s,
                            input int max,
                            input string tag);
    int n = 0;
    while (state !== s && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state), 32'(s));
  endtask

  task automatic count_state(input logic [2:0] s,
                             output int n);
    n = 0;
    while (state === s && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    bit saw_ready;
    reset        = 1'b1;
    enable       = 1'b0;
    pwrdwn_req   = 1'b0;
    clear_status = 1'b0;
    locked       = 1'b0;
    tick(3);
    chk("rst_state", 32'(state), 0);
    chk("rst_pll_rst", 32'(pll_rst), 1);
    chk("rst_pwrdwn", 32'(pll_pwrdwn), 0);
    chk("rst_out_reset", 32'(out_reset), 1);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_relock", 32'(relock_count), 0);
    chk("rst_timeout", 32'(timeout_count), 0);

    // nominal lock
    reset  = 1'b0;
    enable = 1'b1;
    tick(1);
    chk("nom_enter_pllrst", 32'(state), 1);
    chk("nom_pll_rst_hi", 32'(pll_rst), 1);
    count_state(3'd1, n);
    chk("nom_pllrst_cycles", 32'(n), 4);
    chk("nom_pll_rst_lo", 32'(pll_rst), 0);
    chk("nom_wait_state", 32'(state), 2);
    tick(10);
    chk("nom_still_wait", 32'(state), 2);
    locked = 1'b1;
    n = 0;
    while (out_reset !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("nom_release_edges", 32'(n), 10);
    chk("nom_ready", 32'(ready), 1);
    chk("nom_run_state", 32'(state), 4);

    // lock loss in RUN
    locked = 1'b0;
    n = 0;
    while (out_reset !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("loss_edges", 32'(n), 3);
    chk("loss_ready", 32'(ready), 0);
    chk("loss_relock", 32'(relock_count), 1);
    chk("loss_state", 32'(state), 1);
    chk("loss_pll_rst", 32'(pll_rst), 1);
    locked = 1'b1;
    tick(11);
    chk("relock_stable", 32'(state), 3);
    chk("relock_not_ready", 32'(ready), 0);
    tick(1);
    chk("relock_run", 32'(state), 4);
    chk("relock_ready", 32'(ready), 1);

    // power-down from RUN
    pwrdwn_req = 1'b1;
    tick(1);
    chk("pd_state", 32'(state), 5);
    chk("pd_pwrdwn", 32'(pll_pwrdwn), 1);
    chk("pd_out_reset", 32'(out_reset), 1);
    chk("pd_pll_rst", 32'(pll_rst), 1);
    chk("pd_ready", 32'(ready), 0);
    tick(3);
    chk("pd_hold", 32'(state), 5);
    pwrdwn_req = 1'b0;
    tick(1);
    chk("pd_idle", 32'(state), 0);
    chk("pd_pwrdwn_off", 32'(pll_pwrdwn), 0);
    tick(1);
    chk("pd_pllrst", 32'(state), 1);

    // lock glitch in STABLE
    locked = 1'b0;
    wait_state(3'd2, 20, "gl_wait");
    locked = 1'b1;
    wait_state(3'd3, 20, "gl_stable");
    tick(3);
    chk("gl_still_stable", 32'(state), 3);
    saw_ready = ready;
    locked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ready) saw_ready = 1'b1;
    end
    chk("gl_back_wait", 32'(state), 2);
    chk("gl_out_reset", 32'(out_reset), 1);
    chk("gl_never_ready", 32'(saw_ready), 0);

    // lock timeout
    enable = 1'b0;
    tick(1);
    chk("to_idle", 32'(state), 0);
    enable = 1'b1;
    wait_state(3'd2, 20, "to_wait");
    count_state(3'd2, n);
    chk("to_wait_cycles", 32'(n), 32);
    chk("to_pll_rst", 32'(pll_rst), 1);
    chk("to_count1", 32'(timeout_count), 1);
    count_state(3'd1, n);
    chk("to_rst2_cycles", 32'(n), 4);
    count_state(3'd2, n);
    chk("to_wait2_cycles", 32'(n), 32);
    chk("to_count2", 32'(timeout_count), 2);

    // saturation and clear-vs-increment
    n = 0;
    while (timeout_count !== 8'd255 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("sat_reach", 32'(timeout_count), 255);
    wait_state(3'd2, 10, "sat_wait");
    count_state(3'd2, n);
    chk("sat_wait_cycles", 32'(n), 32);
    chk("sat_hold", 32'(timeout_count), 255);
    wait_state(3'd2, 10, "clr_wait");
    tick(31);
    clear_status = 1'b1;
    tick(1);
    clear_status = 1'b0;
    chk("clr_timed_out", 32'(state), 1);
    chk("clr_wins", 32'(timeout_count), 0);

    // reset while in RUN
    locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("rr_run", 32'(state), 4);
    reset = 1'b1;
    tick(1);
    chk("rr_state", 32'(state), 0);
    chk("rr_pll_rst", 32'(pll_rst), 1);
    chk("rr_out_reset", 32'(out_reset), 1);
    chk("rr_ready", 32'(ready), 0);
    chk("rr_relock", 32'(relock_count), 0);
    reset = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
